// File: rtl/crono_ctrl.sv
// Stopwatch control unit: key synchronisation and debouncing, start/pause/lap/clear
// sequencing, and the centisecond prescaler that produces tick/clr/lap_load strobes.
module crono_ctrl #(
    parameter int CLK_DIV    = 50000,
    parameter int DEB_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key0,
    input  logic       key1,
    output logic       tick,
    output logic       clr,
    output logic       lap_load,
    output logic       frozen,
    output logic       running,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_LAP   = 2'b11;

    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    logic [1:0]    keys;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    level;
    logic [1:0]    press;
    logic [DW-1:0] deb_cnt [2];
    logic [PW-1:0] pre;

    logic [1:0] nxt_state;
    logic       nxt_clr;
    logic       nxt_lap;
    logic       nxt_running;

    assign keys = {key1, key0};

    // Index 0 is key0, index 1 is key1; press is a registered one-cycle pulse on a
    // debounced falling edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            level <= '1;
            press <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    level[i]   <= sync2[i];
                    deb_cnt[i] <= '0;
                    press[i]   <= ~sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // key1 has priority: a key0 press in the same cycle is dropped.
    always_comb begin
        nxt_state = state;
        nxt_clr   = 1'b0;
        nxt_lap   = 1'b0;
        if (press[1]) begin
            case (state)
                S_IDLE:  nxt_state = S_RUN;
                S_RUN:   nxt_state = S_PAUSE;
                S_PAUSE: nxt_state = S_RUN;
                default: nxt_state = S_PAUSE;
            endcase
        end else if (press[0]) begin
            case (state)
                S_IDLE:  nxt_clr = 1'b1;
                S_RUN: begin
                    nxt_state = S_LAP;
                    nxt_lap   = 1'b1;
                end
                S_PAUSE: begin
                    nxt_state = S_IDLE;
                    nxt_clr   = 1'b1;
                end
                default: nxt_state = S_RUN;
            endcase
        end
        nxt_running = (nxt_state == S_RUN) || (nxt_state == S_LAP);
    end

    // tick is gated by the next running level so no tick lands in the first
    // PAUSE/IDLE cycle; the prescaler still wraps and PAUSE keeps its phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            clr      <= 1'b0;
            lap_load <= 1'b0;
            frozen   <= 1'b0;
            running  <= 1'b0;
            tick     <= 1'b0;
            pre      <= '0;
        end else begin
            state    <= nxt_state;
            clr      <= nxt_clr;
            lap_load <= nxt_lap;
            frozen   <= (nxt_state == S_LAP);
            running  <= nxt_running;
            tick     <= running && nxt_running && (pre == PRE_MAX);
            if (nxt_clr || (state == S_IDLE)) begin
                pre <= '0;
            end else if (running) begin
                pre <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
            end
        end
    end

endmodule
